// File: rtl/vga_out.sv
// VGA timing generator with registered pixel, sync and frame-start outputs.
// Defining VGA_TEST_PATTERN_EN replaces the draw inputs with eight vertical colour bars.
module vga_out #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 64,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 200,
   parameter int V_ACTIVE = 800,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  draw_r,
   input  logic [3:0]  draw_g,
   input  logic [3:0]  draw_b,
   output logic [10:0] curr_x,
   output logic [9:0]  curr_y,
   output logic [3:0]  pix_r,
   output logic [3:0]  pix_g,
   output logic [3:0]  pix_b,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Thresholds sized to the counter width so every compare is unsigned and untruncated
   localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] X_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  Y_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] x_reg, x_next;
   logic [9:0]  y_reg, y_next;
   logic        hsync_reg, vsync_reg, frame_start_reg;
   logic        visible;

   logic [3:0]  draw_c [3];
   logic [3:0]  src_c  [3];
   logic [3:0]  pix_c  [3];

   always_comb begin
      x_next = x_reg + 11'd1;
      y_next = y_reg;
      if (x_reg == X_LAST) begin
         x_next = '0;
         y_next = (y_reg == Y_LAST) ? '0 : y_reg + 10'd1;
      end
   end

   assign visible = (x_reg < X_VIS) && (y_reg < Y_VIS);

   always_ff @(posedge clk) begin
      if (rst) begin
         x_reg           <= '0;
         y_reg           <= '0;
         hsync_reg       <= 1'b1;
         vsync_reg       <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         x_reg           <= x_next;
         y_reg           <= y_next;
         hsync_reg       <= !((x_reg >= HS_START) && (x_reg < HS_END));
         vsync_reg       <= (y_reg >= VS_START) && (y_reg < VS_END);
         frame_start_reg <= (x_reg == '0) && (y_reg == '0);
      end
   end

   assign draw_c[0] = draw_r;
   assign draw_c[1] = draw_g;
   assign draw_c[2] = draw_b;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
   logic [2:0] bar_idx;

   // Bar index bit 2 drives red, bit 1 green, bit 0 blue
   assign bar_idx = 3'(x_reg / BAR_W);
`endif

   // Channel 0 = red, 1 = green, 2 = blue
   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [3:0] pix_c_reg;

`ifdef VGA_TEST_PATTERN_EN
      assign src_c[gi] = {4{bar_idx[2-gi]}};
`else
      assign src_c[gi] = draw_c[gi];
`endif

      always_ff @(posedge clk) begin
         if (rst)
            pix_c_reg <= 4'h0;
         else
            pix_c_reg <= visible ? src_c[gi] : 4'h0;
      end

      assign pix_c[gi] = pix_c_reg;
   end

   assign curr_x      = x_reg;
   assign curr_y      = y_reg;
   assign pix_r       = pix_c[0];
   assign pix_g       = pix_c[1];
   assign pix_b       = pix_c[2];
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_out.sv
// Directed bench: full-size instance for line timing, a shrunken instance for frame timing.
module tb_vga_out;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst_s;
   logic [3:0]  draw_r, draw_g, draw_b;

   logic [10:0] curr_x;
   logic [9:0]  curr_y;
   logic [3:0]  pix_r, pix_g, pix_b;
   logic        hsync, vsync, frame_start;

   logic [10:0] s_x;
   logic [9:0]  s_y;
   logic [3:0]  s_r, s_g, s_b;
   logic        s_hsync, s_vsync, s_fs;

   int checks = 0;
   int failures = 0;

   vga_out dut (
      .clk(clk), .rst(rst),
      .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
      .curr_x(curr_x), .curr_y(curr_y),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
   );

   // 16 x 12 raster: hsync low x=10..12, vsync high y=7..9, 192 cycles per frame
   vga_out #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(3), .V_BP(2)
   ) dut_s (
      .clk(clk), .rst(rst_s),
      .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
      .curr_x(s_x), .curr_y(s_y),
      .pix_r(s_r), .pix_g(s_g), .pix_b(s_b),
      .hsync(s_hsync), .vsync(s_vsync), .frame_start(s_fs)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Expected colour of a visible pixel at column x for bar width bar_w
   function automatic logic [11:0] exp_rgb(input int x, input int bar_w);
`ifdef VGA_TEST_PATTERN_EN
      logic [2:0] kb;
      kb = 3'(x / bar_w);
      return {{4{kb[2]}}, {4{kb[1]}}, {4{kb[0]}}};
`else
      if (bar_w < 0) return 12'h000;
      if (x < 0) return 12'h000;
      return 12'hFA5;
`endif
   endfunction

   initial begin
      int pix_errs, hs_cnt, hs_first, hs_last, vs_cnt, vs_first, fs_cnt, fs_second, n;
      logic [11:0] exp;
      logic found;

      rst = 1'b1; rst_s = 1'b1;
      draw_r = 4'hF; draw_g = 4'hA; draw_b = 4'h5;

      // Reset held for three edges
      tick(); tick(); tick();
      check("rst_x", 32'(curr_x), 0);
      check("rst_y", 32'(curr_y), 0);
      check("rst_pix", 32'({pix_r, pix_g, pix_b}), 0);
      check("rst_hsync", 32'(hsync), 1);
      check("rst_vsync", 32'(vsync), 0);
      check("rst_fs", 32'(frame_start), 0);
      rst = 1'b0;
      check("rel_x0", 32'(curr_x), 0);
      tick();
      check("rel_fs", 32'(frame_start), 1);
      check("rel_x1", 32'(curr_x), 1);

      // One full line: sample t shows the outputs belonging to curr_x = t
      pix_errs = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; vs_cnt = 0;
      for (int t = 0; t < 1680; t++) begin
         exp = (t < 1280) ? exp_rgb(t, 160) : 12'h000;
         if ({pix_r, pix_g, pix_b} !== exp) pix_errs++;
         if (hsync === 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = t;
            hs_last = t;
         end
         if (vsync !== 1'b0) vs_cnt++;
         if (t == 1) check("fs_once", 32'(frame_start), 0);
         if (t == 0 || t == 160 || t == 1279 || t == 1280)
            check($sformatf("pix_at_%0d", t), 32'({pix_r, pix_g, pix_b}), 32'(exp));
         tick();
      end
      check("line_pix_errs", 32'(pix_errs), 0);
      check("hs_low_cnt", 32'(hs_cnt), 136);
      check("hs_first", 32'(hs_first), 1344);
      check("hs_last", 32'(hs_last), 1479);
      check("vs_line0", 32'(vs_cnt), 0);
      check("line_wrap_x", 32'(curr_x), 1);
      check("line_wrap_y", 32'(curr_y), 1);

      // Line wrap 1679,10 -> 0,11
      found = 1'b0;
      for (int i = 0; i < 20000 && !found; i++) begin
         if (curr_x == 11'd1679 && curr_y == 10'd10) found = 1'b1;
         else tick();
      end
      check("wait_1679_10", 32'(found), 1);
      tick();
      check("wrap_x", 32'(curr_x), 0);
      check("wrap_y", 32'(curr_y), 11);

      // One-cycle reset mid-line at x=700
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (curr_x == 11'd700) found = 1'b1;
         else tick();
      end
      check("wait_x700", 32'(found), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_x", 32'(curr_x), 0);
      check("mid_rst_y", 32'(curr_y), 0);
      check("mid_rst_pix", 32'({pix_r, pix_g, pix_b}), 0);
      check("mid_rst_hs", 32'(hsync), 1);
      check("mid_rst_fs", 32'(frame_start), 0);
      tick();
      check("mid_rst_fs1", 32'(frame_start), 1);

      // Reset inside the hsync pulse must end it at once
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (curr_x == 11'd1400) found = 1'b1;
         else tick();
      end
      check("wait_x1400", 32'(found), 1);
      check("hs_in_pulse", 32'(hsync), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("hs_abort", 32'(hsync), 1);
      check("hs_abort_x", 32'(curr_x), 0);

      // Shrunken raster: two full frames
      rst_s = 1'b0;
      check("s_rel_x", 32'(s_x), 0);
      check("s_rel_fs", 32'(s_fs), 0);
      tick();
      fs_cnt = 0; fs_second = -1; vs_cnt = 0; vs_first = -1;
      hs_cnt = 0; hs_first = -1; pix_errs = 0;
      for (int t = 0; t < 384; t++) begin
         n = t % 16;
         exp = (n < 8 && ((t / 16) % 12) < 6) ? exp_rgb(n, 1) : 12'h000;
         if ({s_r, s_g, s_b} !== exp) pix_errs++;
         if (s_fs === 1'b1) begin
            fs_cnt++;
            if (t > 0) fs_second = t;
         end
         if (s_vsync === 1'b1) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = t;
         end
         if (s_hsync === 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = t;
         end
         tick();
      end
      check("s_pix_errs", 32'(pix_errs), 0);
      check("s_fs_cnt", 32'(fs_cnt), 2);
      check("s_frame_period", 32'(fs_second), 192);
      check("s_vs_cnt", 32'(vs_cnt), 96);
      check("s_vs_first", 32'(vs_first), 112);
      check("s_hs_cnt", 32'(hs_cnt), 72);
      check("s_hs_first", 32'(hs_first), 10);

      // Frame wrap 15,11 -> 0,0
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (s_x == 11'd15 && s_y == 10'd11) found = 1'b1;
         else tick();
      end
      check("s_wait_last", 32'(found), 1);
      tick();
      check("s_wrap_x", 32'(s_x), 0);
      check("s_wrap_y", 32'(s_y), 0);

      // Reset during vsync must drop it and restart the frame
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (s_vsync == 1'b1 && s_x == 11'd5) found = 1'b1;
         else tick();
      end
      check("s_wait_vs", 32'(found), 1);
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      check("s_rst_vs", 32'(s_vsync), 0);
      check("s_rst_hs", 32'(s_hsync), 1);
      check("s_rst_xy", 32'({s_x, s_y}), 0);
      check("s_rst_fs", 32'(s_fs), 0);
      tick();
      check("s_rst_fs1", 32'(s_fs), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_out.md
VGA_OUT -- requirements
Module: vga_out

Interface
REQ-001 Parameter H_ACTIVE, 1280, visible pixels per line.
REQ-002 Parameter H_FP, 64, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, 136, horizontal sync width (pixels).
REQ-004 Parameter H_BP, 200, horizontal back porch (pixels); H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1680.
REQ-005 Parameter V_ACTIVE, 800, visible lines per frame.
REQ-006 Parameter V_FP, 1, vertical front porch (lines).
REQ-007 Parameter V_SYNC, 3, vertical sync width (lines).
REQ-008 Parameter V_BP, 24, vertical back porch (lines); V_TOTAL = 828.
REQ-009 Clock and reset: one clock; reset is synchronous and active-high.
REQ-010 clk  input  1  pixel clock (83.46 MHz nominal); all state changes on its rising edge.
REQ-011 rst  input  1  synchronous active-high reset.
REQ-012 draw_r  input  4  red from the drawing stage for the pixel at curr_x/curr_y.
REQ-013 draw_g  input  4  green, same timing as draw_r.
REQ-014 draw_b  input  4  blue, same timing as draw_r.
REQ-015 curr_x  output  11  horizontal counter, 0..H_TOTAL-1.
REQ-016 curr_y  output  10  vertical counter, 0..V_TOTAL-1.
REQ-017 pix_r  output  4  red to the VGA connector.
REQ-018 pix_g  output  4  green to the VGA connector.
REQ-019 pix_b  output  4  blue to the VGA connector.
REQ-020 hsync  output  1  horizontal sync, active-low.
REQ-021 vsync  output  1  vertical sync, active-high.
REQ-022 frame_start  output  1  single-cycle pulse, aligned with pix_* for pixel (0,0).

Function
REQ-023 curr_x SHALL increment every cycle, wrapping H_TOTAL-1 -> 0.
REQ-024 curr_y SHALL increment only in the cycle curr_x wraps, wrapping V_TOTAL-1 -> 0 (both wrap together at (1679,827) -> (0,0)).
REQ-025 draw_r/g/b are combinational from curr_x/curr_y; the block SHALL register them, giving pix_* exactly 1 cycle latency after the curr_x/curr_y values they belong to.
REQ-026 Visible = (curr_x < H_ACTIVE) and (curr_y < V_ACTIVE), evaluated on the count being registered; outside visible, pix_r/g/b SHALL be 4'h0 regardless of draw inputs.
REQ-027 hsync SHALL be registered low when H_ACTIVE+H_FP <= curr_x < H_ACTIVE+H_FP+H_SYNC (1344..1479), else high; same 1-cycle latency as pix_*.
REQ-028 vsync SHALL be registered high when V_ACTIVE+V_FP <= curr_y < V_ACTIVE+V_FP+V_SYNC (801..803), for all curr_x on those lines, else low; same latency.
REQ-029 frame_start SHALL be 1 in the cycle pix_* shows pixel (0,0), i.e. the cycle after curr_x=0, curr_y=0; 0 otherwise.
REQ-030 Counter comparisons SHALL be unsigned at full port width; no intermediate truncation.

Reset
REQ-031 While rst=1 at a clock edge: curr_x=0, curr_y=0, pix_r/g/b=0, hsync=1, vsync=0, frame_start=0.
REQ-032 Reset asserted mid-line or mid-frame SHALL abort the frame; the first cycle after rst deasserts presents curr_x=0, curr_y=0, and frame_start pulses one cycle later.
REQ-033 No output SHALL change asynchronously to clk.

Configuration
REQ-034 Macro VGA_TEST_PATTERN_EN: when defined, visible pixels SHALL show 8 vertical colour bars each H_ACTIVE/8 = 160 pixels wide, bar index k = curr_x[10:0]/160, colour r=g=b... specifically pix_r={4{k[2]}}, pix_g={4{k[1]}}, pix_b={4{k[0]}}, draw_* ignored; timing, sync and blanking unchanged.
REQ-035 When VGA_TEST_PATTERN_EN is undefined, pix_* SHALL follow REQ-025/026 and no pattern logic SHALL be synthesised.

Verification
REQ-036 Hold rst=1 3 cycles, release -> curr_x=0,curr_y=0 first cycle; pix_*=0, hsync=1, vsync=0; frame_start=1 one cycle later.
REQ-037 draw_r/g/b=F/A/5 constant, run one line -> pix_*=F/A/5 for 1280 cycles then 0 for 400; hsync low exactly 136 cycles starting 1345 cycles after curr_x=0.
REQ-038 Run one full frame -> line period 1680 cycles, frame period 1391040 cycles, vsync high exactly 3 lines (5040 cycles), frame_start once per frame.
REQ-039 At curr_x=1679,curr_y=827 -> next cycle curr_x=0,curr_y=0; at curr_x=1679,curr_y=10 -> curr_y=11.
REQ-040 Assert rst at curr_x=700,curr_y=400 for 1 cycle -> counters restart at (0,0), no partial sync pulse emitted, outputs match REQ-031.
REQ-041 With VGA_TEST_PATTERN_EN, draw_*=0 -> pix at curr_x=0 is 0/0/0, curr_x=160 is 0/0/F, curr_x=1279 is F/F/F; blanking still 0.
